// File: rtl/apb_master.sv
// APB3 initiator: turns single-beat valid/ready commands into SETUP/ACCESS
// transfers and returns one response strobe per command, with a wait-state timeout.
module apb_master #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  assign cmd_ready = (state == IDLE);

  // The APB address/data registers double as the latched command.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr    <= cmd_addr;
            pwrite   <= cmd_write;
            pwdata   <= cmd_wdata;
            psel     <= 1'b1;
            penable  <= 1'b0;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= RESP;
          end else begin
            // Counter tops out at TIMEOUT; it is cleared again on the next SETUP.
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_cnt == LAST_WAIT) begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              psel      <= 1'b0;
              penable   <= 1'b0;
              state     <= RESP;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
